pcm_playback_scheduler: RTL and testbench
=========================================

Name: pcm_playback_scheduler

Overview:
Sample-rate pacer and buffer that feeds the PCM-to-PWM converter. Accepts signed 16-bit PCM over a valid/ready stream into a small FIFO. Emits one sample per programmed sample period as pcm_out plus a multi-cycle pcm_valid strobe, wide enough for the converter's double-flop edge detector. Sequences start-up priming, steady playback, underrun handling, drain-on-stop and flush.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >= 2)
PRIME_LVL, 8, FIFO occupancy required before playback starts (1..DEPTH)
STROBE_LEN, 4, cycles pcm_valid is held high per sample (>= 2)
DIV_W, 16, width of rate_div

Ports:
clk  input  1  single clock
rst  input  1  reset; synchronous and active-low (asserted when 0)
enable  input  1  1 = play, 0 = stop (drain)
flush  input  1  synchronous flush pulse
rate_div  input  DIV_W  sample period in clk cycles minus 1
s_pcm  input  16  signed PCM sample in
s_valid  input  1  s_pcm valid
s_ready  output  1  FIFO can accept
pcm_out  output  16  signed sample to converter
pcm_valid  output  1  sample strobe
busy  output  1  state != IDLE
fifo_level  output  $clog2(DEPTH)+1  current occupancy
underrun_cnt  output  8  saturating underrun count

Behaviour:
- Reset (rst==0 at posedge): FIFO empty, state IDLE, pcm_out=0, pcm_valid=0, busy=0, fifo_level=0, underrun_cnt=0, period counter=0. s_ready=1 from the first cycle after reset.
- FIFO: push when s_valid && s_ready. s_ready = !full in every state, including IDLE. Pop only on a tick with level>0. Push+pop in the same cycle leaves the level unchanged. There is no empty bypass: a pop on an empty FIFO is an underrun even if a push occurs that cycle.
- Period counter: held at 0 outside RUN/DRAIN. Otherwise counts 0..P, where P = max(latched rate_div, 2*STROBE_LEN-1). Tick when counter==P, then counter returns to 0.
- rate_div is latched on the IDLE->PRIME transition and ignored thereafter.
- States:
  - IDLE: enable=1 -> PRIME.
  - PRIME: enable=0 -> IDLE. fifo_level>=PRIME_LVL -> RUN, with the counter at 0 in the first RUN cycle.
  - RUN: enable=0 -> DRAIN; the counter keeps running.
  - DRAIN: plays out the remaining samples. The first tick that finds the FIFO empty emits a 0 sample (no underrun count), then -> IDLE.
- Tick with data: pop the FIFO head. pcm_out is updated on the next cycle. pcm_valid=1 on that same cycle and held exactly STROBE_LEN cycles, then 0. pcm_out is stable for the whole period.
- Tick in RUN with the FIFO empty: pcm_out=0 (silence, 50% duty), pcm_valid strobes normally, underrun_cnt+1 saturating at 255. Stay in RUN.
- underrun_cnt clears on reset and on IDLE->PRIME.
- flush=1: next cycle FIFO empty, pcm_out=0, pcm_valid=0, counter=0, state IDLE. A push in the flush cycle is discarded. flush has priority over all but reset. If enable is still 1, the next cycle enters PRIME.
- Reset mid-operation behaves identically to power-on reset.

Test Plan:
(Parameters for all scenarios: DEPTH=16, PRIME_LVL=8, STROBE_LEN=4, rate_div=9.)
1. Hold rst=0 for 3 cycles with random inputs -> all outputs 0 and busy=0; s_ready=1 on the first cycle after release.
2. Prime and steady play:
   - Stimulus: enable=1; push 100..115 back-to-back; RUN entered at T0.
   - Response: pcm_out=100 with pcm_valid=1 over T0+10..T0+13, pcm_valid=0 at T0+14; pcm_out=101 with strobe at T0+20.
3. Underrun: as scenario 2, but push only 8 samples, then stop -> ninth strobe carries pcm_out=0 and underrun_cnt=1; tenth strobe gives underrun_cnt=2; state remains RUN.
4. Drain:
   - Stimulus: in RUN with fifo_level=3, drop enable.
   - Response: the next three strobes carry the queued samples, a fourth strobe carries 0, then busy=0; underrun_cnt is unchanged.
5. Backpressure: enable=0, push 20 samples with s_valid held high -> s_ready drops after the 16th accept, fifo_level=16, samples 17-20 are held upstream, state stays IDLE.
6. Flush and edge cases:
   - Flush mid-strobe in RUN with level 5 -> next cycle fifo_level=0, pcm_out=0, pcm_valid=0, busy=0 (enable=0).
   - rate_div=2 -> strobes are spaced 8 cycles apart (clamped P=7).

Source files
------------

// File: rtl/pcm_playback_scheduler.sv
// Sample-rate pacer feeding the PCM-to-PWM converter: stream FIFO, period counter,
// widened pcm_valid strobe and IDLE/PRIME/RUN/DRAIN playback sequencing.
module pcm_playback_scheduler #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PRIME_LVL  = 8,
    parameter int unsigned STROBE_LEN = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [DIV_W-1:0]          rate_div,
    input  logic signed [15:0]        s_pcm,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic signed [15:0]        pcm_out,
    output logic                      pcm_valid,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [7:0]                underrun_cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned MIN_P = 2 * STROBE_LEN - 1;
    localparam int unsigned SW    = $clog2(STROBE_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic signed [15:0]     mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [DIV_W-1:0]       cnt_q, period_q;
    logic [SW-1:0]          stb_left;
    logic [LVL_W-1:0]       level_d;
    logic                   push, pop, tick, running, underrun, start, fifo_empty;

    // Next-state and per-cycle control decode
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        running    = (state_q == RUN) || (state_q == DRAIN);
        fifo_empty = (fifo_level == '0);
        tick       = running && (cnt_q == period_q);
        pop        = tick && !fifo_empty;
        underrun   = tick && fifo_empty && (state_q == RUN);
        push       = s_valid && s_ready && !flush;
        level_d    = fifo_level + LVL_W'(push) - LVL_W'(pop);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PRIME;
                    start   = 1'b1;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (fifo_level >= LVL_W'(PRIME_LVL)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tick && fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            start   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_pcm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            s_ready      <= 1'b0;
            cnt_q        <= '0;
            period_q     <= DIV_W'(MIN_P);
            pcm_out      <= '0;
            pcm_valid    <= 1'b0;
            stb_left     <= '0;
            busy         <= 1'b0;
            underrun_cnt <= '0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            s_ready      <= 1'b1;
            cnt_q        <= '0;
            pcm_out      <= '0;
            pcm_valid    <= 1'b0;
            stb_left     <= '0;
            busy         <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= level_d;
            s_ready    <= (level_d != LVL_W'(DEPTH));
            cnt_q      <= (running && !tick) ? cnt_q + DIV_W'(1) : '0;
            busy       <= (state_d != IDLE);

            // Period is clamped so consecutive strobes always leave a low gap
            if (start) begin
                period_q     <= (rate_div < DIV_W'(MIN_P)) ? DIV_W'(MIN_P) : rate_div;
                underrun_cnt <= '0;
            end else if (underrun && (underrun_cnt != 8'hFF)) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end

            if (tick) begin
                pcm_out   <= pop ? mem[rd_ptr] : '0;
                pcm_valid <= 1'b1;
                stb_left  <= SW'(STROBE_LEN - 1);
            end else if (stb_left != '0) begin
                stb_left  <= stb_left - SW'(1);
            end else begin
                pcm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcm_playback_scheduler.sv
// Directed and randomized bench for pcm_playback_scheduler against a queue-based
// playback model driven by absolute tick times.
module tb_pcm_playback_scheduler;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned PRIME_LVL  = 8;
    localparam int unsigned STROBE_LEN = 4;
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned LVL_W      = $clog2(DEPTH) + 1;
    localparam int          MIN_P      = 2 * STROBE_LEN - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic                   flush;
    logic [DIV_W-1:0]       rate_div;
    logic [15:0]            s_pcm;
    logic                   s_valid;
    logic                   s_ready;
    logic [15:0]            pcm_out;
    logic                   pcm_valid;
    logic                   busy;
    logic [LVL_W-1:0]       fifo_level;
    logic [7:0]             underrun_cnt;

    always #5 clk = ~clk;

    pcm_playback_scheduler #(
        .DEPTH      (DEPTH),
        .PRIME_LVL  (PRIME_LVL),
        .STROBE_LEN (STROBE_LEN),
        .DIV_W      (DIV_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flush        (flush),
        .rate_div     (rate_div),
        .s_pcm        (s_pcm),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .pcm_out      (pcm_out),
        .pcm_valid    (pcm_valid),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt)
    );

    typedef enum int {M_IDLE, M_PRIME, M_PLAY, M_DRAIN} mode_t;

    logic [15:0] mq[$];
    mode_t       mode        = M_IDLE;
    int          cyc         = 0;
    int          next_tick   = 0;
    int          valid_until = -1;
    int          period      = MIN_P;
    int          exp_urc     = 0;
    logic [15:0] exp_out     = '0;
    bit          exp_ready   = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;
    bit          last_valid  = 1'b0;
    bit          rose        = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        int    lvl0;
        bit    tick;
        bit    acc;
        mode_t m0;
        if (!rst) begin
            mq.delete();
            mode        = M_IDLE;
            exp_out     = '0;
            valid_until = -1;
            exp_urc     = 0;
            exp_ready   = 1'b0;
        end else if (flush) begin
            mq.delete();
            mode        = M_IDLE;
            exp_out     = '0;
            valid_until = -1;
            exp_ready   = 1'b1;
        end else begin
            m0   = mode;
            lvl0 = mq.size();
            acc  = s_valid && exp_ready;
            tick = ((m0 == M_PLAY) || (m0 == M_DRAIN)) && (cyc == next_tick);
            if (tick) begin
                valid_until = cyc + STROBE_LEN;
                next_tick   = cyc + period + 1;
                if (lvl0 > 0) begin
                    exp_out = mq.pop_front();
                end else begin
                    exp_out = '0;
                    if (m0 == M_PLAY) begin
                        if (exp_urc < 255) exp_urc++;
                    end else begin
                        mode = M_IDLE;
                    end
                end
            end
            if (acc) mq.push_back(s_pcm);
            case (m0)
                M_IDLE: begin
                    if (enable) begin
                        mode    = M_PRIME;
                        period  = (int'(rate_div) > MIN_P) ? int'(rate_div) : MIN_P;
                        exp_urc = 0;
                    end
                end
                M_PRIME: begin
                    if (!enable) begin
                        mode = M_IDLE;
                    end else if (lvl0 >= int'(PRIME_LVL)) begin
                        mode      = M_PLAY;
                        next_tick = cyc + 1 + period;
                    end
                end
                M_PLAY: begin
                    if (!enable) mode = M_DRAIN;
                end
                default: ;
            endcase
            exp_ready = (mq.size() < int'(DEPTH));
        end
        cyc++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("pcm_out", {16'h0, pcm_out}, {16'h0, exp_out});
        chk("pcm_valid", 32'(pcm_valid), 32'(cyc <= valid_until));
        chk("busy", 32'(busy), 32'(mode != M_IDLE));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(exp_urc));
        rose       = pcm_valid && !last_valid;
        last_valid = pcm_valid;
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!rose && n < 100);
        chk(tag, 32'(rose), 32'd1);
    endtask

    initial begin
        int          acc;
        int          n;
        int          t1;
        int          dens;
        logic [15:0] vals [8];

        rst = 1'b0; enable = 1'b0; flush = 1'b0;
        rate_div = 16'd9; s_pcm = '0; s_valid = 1'b0;
        dens = 5;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            enable   = 1'($urandom);
            flush    = 1'($urandom);
            s_valid  = 1'($urandom);
            s_pcm    = 16'($urandom);
            rate_div = 16'($urandom);
            step();
        end
        chk("rst_pcm_valid", 32'(pcm_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b1; enable = 1'b0; flush = 1'b0; s_valid = 1'b0; rate_div = 16'd9;
        step();
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        // Prime and steady play
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_pcm   = 16'(100 + i);
            step();
        end
        s_valid = 1'b0;
        wait_strobe("s2_first_strobe");
        chk("s2_first_out", {16'h0, pcm_out}, 32'd100);
        step(); step(); step();
        chk("s2_strobe_last_hi", 32'(pcm_valid), 32'd1);
        step();
        chk("s2_strobe_low", 32'(pcm_valid), 32'd0);
        wait_strobe("s2_second_strobe");
        chk("s2_second_out", {16'h0, pcm_out}, 32'd101);
        enable = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        // Underrun after only PRIME_LVL samples
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_pcm   = 16'($urandom);
            step();
        end
        s_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            wait_strobe("s3_strobe");
            if (k == 9) begin
                chk("s3_ninth_out", {16'h0, pcm_out}, 32'd0);
                chk("s3_ninth_urc", 32'(underrun_cnt), 32'd1);
            end
            if (k == 10) begin
                chk("s3_tenth_urc", 32'(underrun_cnt), 32'd2);
                chk("s3_still_busy", 32'(busy), 32'd1);
            end
        end

        // Drain with three samples queued
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = 16'($urandom);
            s_valid = 1'b1;
            s_pcm   = vals[i];
            step();
        end
        s_valid = 1'b0;
        n = 0;
        while (fifo_level != LVL_W'(3) && n < 200) begin
            step();
            n++;
        end
        chk("s4_reach_lvl3", 32'(fifo_level), 32'd3);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_strobe("s4_drain_strobe");
            chk("s4_drain_out", {16'h0, pcm_out}, {16'h0, vals[5 + k]});
        end
        wait_strobe("s4_final_strobe");
        chk("s4_final_out", {16'h0, pcm_out}, 32'd0);
        chk("s4_idle", 32'(busy), 32'd0);
        chk("s4_urc", 32'(underrun_cnt), 32'd0);

        // Backpressure while stopped
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_pcm   = 16'($urandom);
            if (s_ready) acc++;
            step();
        end
        s_valid = 1'b0;
        chk("s5_accepted", 32'(acc), 32'd16);
        chk("s5_level", 32'(fifo_level), 32'd16);
        chk("s5_ready", 32'(s_ready), 32'd0);
        chk("s5_idle", 32'(busy), 32'd0);

        // Flush mid-strobe with five samples queued
        enable = 1'b1; rate_div = 16'd9;
        n = 0;
        while (!(fifo_level == LVL_W'(5) && pcm_valid) && n < 300) begin
            step();
            n++;
        end
        chk("s6_reach_lvl5", 32'(fifo_level), 32'd5);
        step();
        enable = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s6_flush_level", 32'(fifo_level), 32'd0);
        chk("s6_flush_out", {16'h0, pcm_out}, 32'd0);
        chk("s6_flush_valid", 32'(pcm_valid), 32'd0);
        chk("s6_flush_busy", 32'(busy), 32'd0);

        // Short rate_div is clamped to the minimum period
        rate_div = 16'd2; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_pcm   = 16'($urandom);
            step();
        end
        s_valid = 1'b0;
        wait_strobe("s6_clamp_a");
        t1 = cyc;
        wait_strobe("s6_clamp_b");
        chk("s6_clamp_spacing", 32'(cyc - t1), 32'd8);

        // Randomized traffic, including flush and mid-run reset
        flush = 1'b1; enable = 1'b0;
        step();
        flush = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 119) == 0) enable = ~enable;
            if (i % 250 == 0) dens = $urandom_range(1, 9);
            flush    = ($urandom_range(0, 299) == 0);
            rst      = ($urandom_range(0, 799) != 0);
            s_valid  = ($urandom_range(0, 9) < dens);
            s_pcm    = 16'($urandom);
            rate_div = 16'($urandom_range(0, 16));
            step();
        end
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
